converter_bi_2_dec: RTL and testbench
=====================================

# converter_bi_2_dec

Iterative IEEE-754 single-precision to decimal converter, the inverse of the team's decimal-to-binary converter. It accepts a 32-bit float and produces a sign bit, the integer part as a 128-bit binary integer, and the fractional part as a 128-bit integer scaled by 10^FRAC_DIGITS (truncated). Start/done handshake, fixed latency. It sits on the readback path of the FP datapath, feeding display and checker logic.

## Interface
- FRAC_DIGITS, 38, number of decimal fraction digits produced; legal range 1..38 (10^38 < 2^128)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- in  in  32  IEEE-754 single operand, captured on accepted start
- busy  out  1  high from the cycle after the accepted start through the done cycle
- done  out  1  one-cycle pulse; results valid from this cycle onward
- sign  out  1  in[31] of the converted operand
- out_floor  out  128  integer part, floor(|x|)
- out_frac  out  128  floor(frac(|x|) * 10^FRAC_DIGITS)
- is_inf  out  1  operand exponent 255, mantissa 0
- is_nan  out  1  operand exponent 255, mantissa nonzero

## Operation
- States: IDLE, UNPACK, DIGIT, DONE.
- IDLE: on start=1, capture in and go to UNPACK. Otherwise stay.
- UNPACK, 1 cycle:
  - e = in[30:23], f = in[22:0].
  - m = {1,f} if e≠0, else {0,f} with e treated as 1.
  - Value = m·2^(e−150).
  - Integer part = m << (e−150) when e ≥ 150, else m >> (150−e). Max (2^24−1)·2^104 fits 128 bits.
  - Fraction register R[149:0] = fractional bits of m aligned so R/2^150 = frac(|x|). Exact, since the minimum exponent is −149.
  - Digit counter = FRAC_DIGITS−1; accumulator = 0.
- DIGIT, one digit per cycle, exactly FRAC_DIGITS cycles:
  - T = R·10 (154 bits).
  - digit = T[153:150]; R ← T[149:0].
  - acc ← acc·10 + digit.
  - Leave DIGIT when the counter reaches 0. No early exit when R=0.
- DONE, 1 cycle:
  - Register sign, out_floor, out_frac=acc, is_inf, is_nan; pulse done.
  - Return to IDLE.
- Specials:
  - e=255 runs the same sequence with floor=0, frac=0 and the matching flag set.
  - ±0 gives floor=0, frac=0, sign preserved.
  - Subnormals are converted exactly, then truncated.
- Rounding: none; truncation toward zero on the fraction only.
- Result outputs hold their value until the next DONE.

## Timing
- Reset: state IDLE; busy=0, done=0, sign=0, out_floor=0, out_frac=0, is_inf=0, is_nan=0.
- Start accepted at edge N → UNPACK during N+1 → DIGIT during N+2..N+1+FRAC_DIGITS → done=1 and outputs updated in cycle N+2+FRAC_DIGITS. That is 40 cycles for the default.
- start while busy: ignored, no queuing.
- start held high in the done cycle: ignored. It is accepted in the following IDLE cycle, so back-to-back throughput is one result per FRAC_DIGITS+3 cycles.
- Reset mid-operation: abort to IDLE and clear all outputs; no done pulse.

## Structure
- Package float_conv_pkg:
  - EXP_BIAS=127, MANT_W=23, FRAC_ALIGN_W=150, DEC_W=128.
  - State enum {IDLE, UNPACK, DIGIT, DONE}.
  - Shared with the decimal-to-binary converter.
- One sub-module, frac_digit_step (combinational):
  - Inputs R[149:0], acc[127:0].
  - Outputs next R, next acc, digit[3:0].

## Test plan
- in=0x40800000 (4.0) → sign=0, floor=4, frac=0; done exactly 40 cycles after start.
- in=0xC0D00000 (−6.5) → sign=1, floor=6, frac=50000000000000000000000000000000000000.
- in=0x3DCCCCCD (0.1f) → floor=0, frac=10000000149011611938476562500000000000.
- Extremes:
  - 0x00000001 → floor=0, frac=0.
  - 0x7F7FFFFF → floor=340282346638528859811704183484516925440, frac=0.
  - 0x80000000 → sign=1, floor=0, frac=0.
- Specials:
  - 0x7F800000 → is_inf=1, is_nan=0.
  - 0xFFC00000 → is_nan=1, sign=1, floor=0, frac=0.
- Handshake and reset:
  - A start pulsed during busy with a different operand leaves the first result unchanged.
  - Deasserting rst_n at cycle 20 of a conversion gives no done, clears all outputs, and the next start converts correctly.

Source files
------------

// File: rtl/float_conv_pkg.sv
// Shared types and constants for the binary/decimal float converters.
// Provides field widths, the converter state encoding and the significand
// alignment helper used during unpack.
package float_conv_pkg;

    localparam int unsigned EXP_BIAS     = 127;
    localparam int unsigned MANT_W       = 23;
    localparam int unsigned EXP_W        = 8;
    localparam int unsigned FLOAT_W      = 32;
    localparam int unsigned SIG_W        = MANT_W + 1;
    localparam int unsigned FRAC_ALIGN_W = 150;
    localparam int unsigned DEC_W        = 128;
    localparam int unsigned EXP_LSB      = MANT_W;
    localparam int unsigned EXP_MSB      = MANT_W + EXP_W - 1;
    localparam int unsigned SIGN_BIT     = FLOAT_W - 1;
    // m * 2^e for the largest finite e (254) stays below 2^(FRAC_ALIGN_W + DEC_W)
    localparam int unsigned ALIGN_W      = FRAC_ALIGN_W + DEC_W;

    typedef enum logic [1:0] {
        IDLE,
        UNPACK,
        DIGIT,
        DONE
    } conv_state_t;

    // |x| * 2^150 as a fixed-point number: upper DEC_W bits are floor(|x|),
    // lower FRAC_ALIGN_W bits are the exact fraction. Subnormals use e = 1.
    function automatic logic [ALIGN_W-1:0] align_value(input logic [FLOAT_W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [SIG_W-1:0] m;
        e = x[EXP_MSB:EXP_LSB];
        if (e == '0) begin
            m = {1'b0, x[MANT_W-1:0]};
            e = EXP_W'(1);
        end else begin
            m = {1'b1, x[MANT_W-1:0]};
        end
        return ALIGN_W'(m) << e;
    endfunction

endpackage

// File: rtl/frac_digit_step.sv
// One decimal digit extraction step: multiplies the binary fraction by ten,
// peels off the integer digit, and shifts it into the decimal accumulator.
// Ports:
//   r          : fraction, value r / 2^150
//   acc        : digits produced so far, as a binary integer
//   r_next_c   : remaining fraction after this digit
//   acc_next_c : acc * 10 + digit
//   digit_c    : digit produced this step (always 0..9)
module frac_digit_step
    import float_conv_pkg::*;
(
    input  logic [FRAC_ALIGN_W-1:0] r,
    input  logic [DEC_W-1:0]        acc,
    output logic [FRAC_ALIGN_W-1:0] r_next_c,
    output logic [DEC_W-1:0]        acc_next_c,
    output logic [3:0]              digit_c
);

    localparam int unsigned T_W = FRAC_ALIGN_W + 4;

    logic [T_W-1:0] t;

    // r * 10 as (r << 3) + (r << 1)
    assign t          = (T_W'(r) << 3) + (T_W'(r) << 1);
    assign digit_c    = t[T_W-1 -: 4];
    assign r_next_c   = t[FRAC_ALIGN_W-1:0];
    assign acc_next_c = (acc << 3) + (acc << 1) + DEC_W'(digit_c);

endmodule

// File: rtl/converter_bi_2_dec.sv
// Iterative IEEE-754 single to decimal converter. Produces the sign, the
// integer part and the fraction truncated to FRAC_DIGITS decimal digits.
// Fixed latency: result visible FRAC_DIGITS+2 cycles after the accept cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start, in  : request and operand, sampled only when idle
//   busy, done : conversion in flight / one-cycle result strobe
//   sign, out_floor, out_frac, is_inf, is_nan : held results
module converter_bi_2_dec
    import float_conv_pkg::*;
#(
    parameter int unsigned FRAC_DIGITS = 38
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FLOAT_W-1:0] in,
    output logic               busy,
    output logic               done,
    output logic               sign,
    output logic [DEC_W-1:0]   out_floor,
    output logic [DEC_W-1:0]   out_frac,
    output logic               is_inf,
    output logic               is_nan
);

    localparam int unsigned CNT_W = $clog2(FRAC_DIGITS + 1);

    conv_state_t             state;
    logic [FLOAT_W-1:0]      op_q;
    logic [DEC_W-1:0]        floor_q;
    logic [DEC_W-1:0]        acc_q;
    logic [FRAC_ALIGN_W-1:0] r_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [ALIGN_W-1:0]      aligned_c;
    logic                    exp_all_ones_c;
    logic                    mant_zero_c;
    logic [FRAC_ALIGN_W-1:0] r_next_c;
    logic [DEC_W-1:0]        acc_next_c;
    logic [3:0]              digit_c;

    // Operand decode, used in UNPACK and when publishing the flags
    assign aligned_c      = align_value(op_q);
    assign exp_all_ones_c = &op_q[EXP_MSB:EXP_LSB];
    assign mant_zero_c    = (op_q[MANT_W-1:0] == '0);

    frac_digit_step u_step (
        .r          (r_q),
        .acc        (acc_q),
        .r_next_c   (r_next_c),
        .acc_next_c (acc_next_c),
        .digit_c    (digit_c)
    );

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            floor_q   <= '0;
            acc_q     <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sign      <= 1'b0;
            out_floor <= '0;
            out_frac  <= '0;
            is_inf    <= 1'b0;
            is_nan    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= in;
                        busy  <= 1'b1;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    // Inf/NaN still run the full digit loop, on a zero value
                    floor_q <= exp_all_ones_c ? '0 : aligned_c[ALIGN_W-1:FRAC_ALIGN_W];
                    r_q     <= exp_all_ones_c ? '0 : aligned_c[FRAC_ALIGN_W-1:0];
                    acc_q   <= '0;
                    cnt_q   <= CNT_W'(FRAC_DIGITS - 1);
                    state   <= DIGIT;
                end
                DIGIT: begin
                    assert (digit_c <= 4'd9);
                    r_q   <= r_next_c;
                    acc_q <= acc_next_c;
                    if (cnt_q == '0) begin
                        // Publish on the last digit so done lands in the DONE cycle
                        done      <= 1'b1;
                        sign      <= op_q[SIGN_BIT];
                        out_floor <= floor_q;
                        out_frac  <= acc_next_c;
                        is_inf    <= exp_all_ones_c & mant_zero_c;
                        is_nan    <= exp_all_ones_c & ~mant_zero_c;
                        state     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_converter_bi_2_dec.sv
// Directed bench for converter_bi_2_dec with an expected-result queue.
module tb_converter_bi_2_dec;

    localparam int unsigned FD = 38;

    typedef struct packed {
        logic         sign;
        logic [127:0] fl;
        logic [127:0] fr;
        logic         inf;
        logic         nan;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [31:0]  in;
    logic         busy;
    logic         done;
    logic         sign;
    logic [127:0] out_floor;
    logic [127:0] out_frac;
    logic         is_inf;
    logic         is_nan;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    converter_bi_2_dec #(.FRAC_DIGITS(FD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in        (in),
        .busy      (busy),
        .done      (done),
        .sign      (sign),
        .out_floor (out_floor),
        .out_frac  (out_frac),
        .is_inf    (is_inf),
        .is_nan    (is_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic exp_t mk(input logic s, input logic [127:0] fl, input logic [127:0] fr,
                                input logic inf, input logic nan);
        exp_t e;
        e.sign = s; e.fl = fl; e.fr = fr; e.inf = inf; e.nan = nan;
        return e;
    endfunction

    // Reference: floor by direct shift, fraction as (fraction bits * 10^FD) >> shift
    function automatic exp_t model(input logic [31:0] x);
        exp_t         r;
        logic [7:0]   e;
        logic [23:0]  m;
        int           ee;
        int           sh;
        logic [299:0] w;
        logic [299:0] p10;
        e  = x[30:23];
        ee = (e == 8'd0) ? 1 : int'(e);
        m  = (e == 8'd0) ? {1'b0, x[22:0]} : {1'b1, x[22:0]};
        r.sign = x[31];
        r.inf  = (e == 8'hFF) && (x[22:0] == 23'd0);
        r.nan  = (e == 8'hFF) && (x[22:0] != 23'd0);
        r.fl   = '0;
        r.fr   = '0;
        if (e != 8'hFF) begin
            if (ee >= 150) begin
                r.fl = 128'(m) << (ee - 150);
            end else begin
                sh   = 150 - ee;
                r.fl = 128'(m >> sh);
                p10  = 300'(1);
                for (int i = 0; i < int'(FD); i++) p10 = p10 * 300'(10);
                w    = 300'(m) & ((300'(1) << sh) - 300'(1));
                w    = (w * p10) >> sh;
                r.fr = w[127:0];
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < int'(FD) + 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done_seen"}, 128'(done), 128'(1));
    endtask

    task automatic cmp_result(input string tag);
        exp_t e;
        chk({tag, "_pending"}, 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_sign"},  128'(sign),   128'(e.sign));
            chk({tag, "_floor"}, out_floor,    e.fl);
            chk({tag, "_frac"},  out_frac,     e.fr);
            chk({tag, "_inf"},   128'(is_inf), 128'(e.inf));
            chk({tag, "_nan"},   128'(is_nan), 128'(e.nan));
        end
    endtask

    // exp_lat counts edges after the accept edge; FD+1 is the 40-cycle case
    task automatic run_op(input string tag, input logic [31:0] x, input exp_t e, input int exp_lat);
        int lat;
        @(negedge clk);
        in    = x;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        wait_done(tag, lat);
        if (exp_lat >= 0) chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        cmp_result(tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 128'(done), 128'(0));
        chk({tag, "_busy_low"},   128'(busy), 128'(0));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"},  128'(busy),   128'(0));
        chk({tag, "_done"},  128'(done),   128'(0));
        chk({tag, "_sign"},  128'(sign),   128'(0));
        chk({tag, "_floor"}, out_floor,    128'(0));
        chk({tag, "_frac"},  out_frac,     128'(0));
        chk({tag, "_inf"},   128'(is_inf), 128'(0));
        chk({tag, "_nan"},   128'(is_nan), 128'(0));
    endtask

    initial begin
        int          lat;
        int          gap;
        int          extra;
        logic [31:0] x;

        rst_n = 1'b0;
        start = 1'b0;
        in    = 32'd0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        run_op("four",    32'h40800000, mk(1'b0, 128'd4, 128'd0, 1'b0, 1'b0), int'(FD) + 1);
        run_op("neg6p5",  32'hC0D00000,
               mk(1'b1, 128'd6, 128'd50000000000000000000000000000000000000, 1'b0, 1'b0), -1);
        run_op("tenth",   32'h3DCCCCCD,
               mk(1'b0, 128'd0, 128'd10000000149011611938476562500000000000, 1'b0, 1'b0), -1);
        run_op("min_sub", 32'h00000001, mk(1'b0, 128'd0, 128'd0, 1'b0, 1'b0), -1);
        run_op("max_fin", 32'h7F7FFFFF,
               mk(1'b0, 128'd340282346638528859811704183484516925440, 128'd0, 1'b0, 1'b0), -1);
        run_op("neg_zero", 32'h80000000, mk(1'b1, 128'd0, 128'd0, 1'b0, 1'b0), -1);
        run_op("pos_inf", 32'h7F800000, mk(1'b0, 128'd0, 128'd0, 1'b1, 1'b0), -1);
        run_op("qnan",    32'hFFC00000, mk(1'b1, 128'd0, 128'd0, 1'b0, 1'b1), -1);
        run_op("max_sub", 32'h007FFFFF, model(32'h007FFFFF), -1);
        run_op("e150",    32'h4B7FFFFF, model(32'h4B7FFFFF), -1);
        run_op("e151",    32'h4B800001, model(32'h4B800001), -1);
        run_op("pi",      32'h40490FDB, model(32'h40490FDB), -1);
        for (int i = 0; i < 4; i++) begin
            x = $urandom();
            run_op("rand", x, model(x), -1);
        end

        // Second start while busy, with a different operand, must be dropped
        @(negedge clk);
        in    = 32'hC0D00000;
        start = 1'b1;
        sb.push_back(mk(1'b1, 128'd6, 128'd50000000000000000000000000000000000000, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        in    = 32'h40800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in    = 32'd0;
        wait_done("busy_start", lat);
        cmp_result("busy_start");
        extra = 0;
        repeat (FD + 6) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk("busy_start_no_extra", 128'(extra), 128'(0));

        // start held through the done cycle: next accept one IDLE cycle later
        @(negedge clk);
        in    = 32'h3DCCCCCD;
        start = 1'b1;
        sb.push_back(mk(1'b0, 128'd0, 128'd10000000149011611938476562500000000000, 1'b0, 1'b0));
        sb.push_back(mk(1'b0, 128'd0, 128'd10000000149011611938476562500000000000, 1'b0, 1'b0));
        @(negedge clk);
        wait_done("b2b_first", lat);
        cmp_result("b2b_first");
        gap = 0;
        while (gap < int'(FD) + 10) begin
            @(negedge clk);
            gap++;
            if (gap == 2) start = 1'b0;
            if (done === 1'b1) break;
        end
        chk("b2b_gap", 128'(gap), 128'(FD + 3));
        cmp_result("b2b_second");

        // Reset in the middle of a conversion
        @(negedge clk);
        in    = 32'h40800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("mid_reset");
        rst_n = 1'b1;
        extra = 0;
        repeat (FD + 6) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk("mid_reset_no_done", 128'(extra), 128'(0));
        run_op("after_reset", 32'hC0D00000,
               mk(1'b1, 128'd6, 128'd50000000000000000000000000000000000000, 1'b0, 1'b0),
               int'(FD) + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
